// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect priority codes, default vectors, fetch step.
package cpu_pkg;

    // Redirect priority codes: a higher value wins.
    typedef logic [1:0] rd_code_t;
    localparam rd_code_t NONE = 2'd0;
    localparam rd_code_t BR   = 2'd1;
    localparam rd_code_t ERET = 2'd2;
    localparam rd_code_t EXC  = 2'd3;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
    localparam int unsigned DEF_STEP      = 4;

    // The HOLD state is the only place where a redirect is buffered.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect arbiter: picks the highest-priority request and
// aligns its target to the fetch step.
import cpu_pkg::*;

module pc_redirect_sel #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned      STEP    = DEF_STEP
) (
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] epc,
    output logic             sel_valid,
    output logic [WIDTH-1:0] sel_target,
    output rd_code_t         sel_code
);

    // STEP is a power of two, so STEP-1 covers exactly the bits to clear.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP) - WIDTH'(1));

    logic [WIDTH-1:0] raw_target;

    // Fixed priority: exception, then exception return, then branch.
    always_comb begin
        raw_target = '0;
        sel_code   = NONE;
        if (exc_valid) begin
            raw_target = EXC_VEC;
            sel_code   = EXC;
        end else if (eret_valid) begin
            raw_target = epc;
            sel_code   = ERET;
        end else if (br_valid) begin
            raw_target = br_target;
            sel_code   = BR;
        end
        sel_valid  = (sel_code != NONE);
        sel_target = raw_target & ALIGN_MASK;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects, a one-entry
// pending-redirect buffer for stalls, EPC capture and an epoch tag.
import cpu_pkg::*;

module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned      STEP      = DEF_STEP,
    parameter int unsigned      EPOCH_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_valid,
    input  logic [WIDTH-1:0]   br_target,
    input  logic               exc_valid,
    input  logic               eret_valid,
    output logic [WIDTH-1:0]   pc_out,
    output logic               pc_valid,
    output logic [EPOCH_W-1:0] epoch,
    output logic [WIDTH-1:0]   epc_out,
    output logic               pend_valid
);

    pc_state_t          state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [WIDTH-1:0]   epc_q, epc_d;
    logic [WIDTH-1:0]   pend_target_q, pend_target_d;
    rd_code_t           pend_code_q, pend_code_d;

    logic               sel_valid;
    logic [WIDTH-1:0]   sel_target;
    rd_code_t           sel_code;
    logic               take;

    pc_redirect_sel #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC),
        .STEP    (STEP)
    ) u_sel (
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .epc        (epc_q),
        .sel_valid  (sel_valid),
        .sel_target (sel_target),
        .sel_code   (sel_code)
    );

    // Next-state: sync reset, reset-release edge, then redirect/stall handling.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = pc_valid_q;
        epoch_d       = epoch_q;
        epc_d         = epc_q;
        pend_target_d = pend_target_q;
        pend_code_d   = pend_code_q;
        // In HOLD a new request must match or beat the buffered one.
        take          = sel_valid && ((state_q == RUN) || (sel_code >= pend_code_q));

        if (!rst) begin
            state_d       = RUN;
            pc_d          = RESET_VEC;
            pc_valid_d    = 1'b0;
            epoch_d       = '0;
            epc_d         = '0;
            pend_target_d = '0;
            pend_code_d   = NONE;
        end else if (!pc_valid_q) begin
            // Release edge: go live without stepping; requests are ignored.
            pc_valid_d = 1'b1;
        end else begin
            if (take) begin
                epoch_d = epoch_q + EPOCH_W'(1);
                if (sel_code == EXC) begin
                    epc_d = pc_q;
                end
            end
            if (stall) begin
                if (take) begin
                    pend_target_d = sel_target;
                    pend_code_d   = sel_code;
                    state_d       = HOLD;
                end
            end else begin
                if (take) begin
                    pc_d = sel_target;
                end else if (state_q == HOLD) begin
                    pc_d = pend_target_q;
                end else begin
                    pc_d = pc_q + WIDTH'(STEP);
                end
                pend_code_d = NONE;
                state_d     = RUN;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        state_q       <= state_d;
        pc_q          <= pc_d;
        pc_valid_q    <= pc_valid_d;
        epoch_q       <= epoch_d;
        epc_q         <= epc_d;
        pend_target_q <= pend_target_d;
        pend_code_q   <= pend_code_d;
    end

    assign pc_out     = pc_q;
    assign pc_valid   = pc_valid_q;
    assign epoch      = epoch_q;
    assign epc_out    = epc_q;
    assign pend_valid = (state_q == HOLD);

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage of the pipelined CPU.
- Generalises the plain stalled PC register:
  - configurable width, reset vector, exception vector and step size;
  - internal increment;
  - prioritised redirect sources (exception, exception return, branch/jump);
  - one-entry pending-redirect buffer, so redirects arriving during a stall are not lost;
  - EPC capture;
  - wrapping epoch tag, so downstream stages can discard stale fetches.

Parameters:
- WIDTH, 32: PC/address width.
- RESET_VEC, 0: pc_out value in reset.
- EXC_VEC, 32'h0000_0080: exception handler entry address.
- STEP, 4: sequential increment in bytes. Must be a power of two, >= 1.
- EPOCH_W, 2: epoch counter width.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, synchronous, active-low.
- stall, input, 1: 1 = hold PC; redirects are buffered rather than applied.
- br_valid, input, 1: branch/jump redirect request.
- br_target, input, WIDTH: branch/jump target.
- exc_valid, input, 1: exception request.
- eret_valid, input, 1: return-from-exception request.
- pc_out, output, WIDTH: current fetch PC.
- pc_valid, output, 1: pc_out is a live fetch address.
- epoch, output, EPOCH_W: redirect generation tag.
- epc_out, output, WIDTH: PC saved at the last accepted exception.
- pend_valid, output, 1: a redirect is buffered (debug/perf).

Behaviour:
- Reset (rst==0 at posedge):
  - pc_out=RESET_VEC, pc_valid=0, epoch=0, epc_out=0, pend_valid=0, state=RUN.
  - Reset mid-operation discards any pending redirect.
- The first posedge with rst==1 sets pc_valid=1. pc_out is not incremented on that edge. pc_valid stays 1 until the next reset.
- Alignment: every redirect target has its low log2(STEP) bits forced to 0.
- Increment: pc_out+STEP, wraps modulo 2^WIDTH.
- Event selection per cycle (rst==1, pc_valid==1), highest priority first:
  - exc_valid: target=EXC_VEC;
  - eret_valid: target=epc_out;
  - br_valid: target=br_target.
  - Lower-priority simultaneous requests are dropped.
- Accepting an event:
  - epoch increments by 1, wrapping modulo 2^EPOCH_W.
  - For an exception, epc_out <= pc_out at that edge.
  - eret reads epc_out before any same-cycle update. eret and exc in the same cycle resolves as exc.
- States:
  - RUN, stall=0:
    - event present: pc_out <= target (1-cycle latency).
    - else if pend_valid: N/A in RUN.
    - else: pc_out <= pc_out+STEP.
  - RUN, stall=1:
    - pc_out held.
    - An event, if present, is captured into the pending register (pend_target, pend_is_exc); pend_valid=1; go to HOLD.
  - HOLD, stall=1:
    - pc_out held.
    - A new event overwrites pending only if its priority >= the stored one. A branch never overwrites a pending exception.
    - Every accepted overwrite increments epoch.
  - HOLD, stall=0:
    - New event present: it is applied directly (priority rules above, including overwrite rule vs pending). pending is cleared.
    - Else: pc_out <= pend_target.
    - In both cases pend_valid=0 and the state returns to RUN.
- No increment ever occurs in the same edge as a redirect load.
- pc_valid==0 (reset-release edge): requests are ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - redirect priority encoding: localparam codes NONE=0, BR=1, ERET=2, EXC=3;
  - default vectors RESET_VEC and EXC_VEC;
  - STEP.
- One natural sub-module: pc_redirect_sel. Combinational priority select and alignment: returns valid, target, code. The stateful logic (pc, pending, epoch, epc) stays in pc_unit.

Test Plan:
1. Reset and run: rst=0 for 3 cycles, then 1; stall=0, no events. Required: pc_out=0,0,0 during reset; pc_valid rises; then pc_out=0,4,8,12; epoch=0.
2. Branch with alignment: at pc_out=8, br_valid=1, br_target=0x103 for 1 cycle. Required: next pc_out=0x100; then 0x104; epoch=1.
3. Branch during stall: stall=1 at pc_out=0x20; br_target=0x40 pulsed in cycle 2; stall released in cycle 5. Required:
   - pc_out=0x20 through the stall; pend_valid=1 from cycle 3;
   - the cycle after release, pc_out=0x40 and pend_valid=0;
   - epoch incremented once.
4. Exception then eret: exc_valid at pc_out=0x1C. Required:
   - pc_out=0x80, epc_out=0x1C, epoch+1;
   - run to 0x88, then eret_valid gives pc_out=0x1C, epoch+2.
5. Priority and overwrite: stall=1; exc pulsed, then br_valid (target 0x200) pulsed; release. Required:
   - pc_out=EXC_VEC; branch ignored; epoch +1 only.
   - Simultaneous exc+br with stall=0 yields EXC_VEC.
6. Wrap and reset mid-stall:
   - WIDTH=8, pc_out=0xFC, STEP=4: next pc_out=0x00.
   - EPOCH_W=2 after 4 redirects: epoch=0.
   - rst=0 while pend_valid=1: pend_valid=0, pc_out=RESET_VEC, and no redirect applied after release.
